// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared constants for the instruction-side program loader.
//   - FSM state encoding (also consumed by ControlUnit decode)
//   - Default NOP instruction word returned for non-program fetches
// -----------------------------------------------------------------------------
package instr_mem_loader_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;   // no program present
   localparam logic [1:0] ST_LOAD  = 2'd1;   // accepting program bytes
   localparam logic [1:0] ST_RUN   = 2'd2;   // program valid, core executes

   localparam logic [7:0] NOP_INSTR_DEFAULT = 8'h00;

   // True when a state value means the core may execute.
   function automatic logic state_is_run(input logic [1:0] st);
      return (st == ST_RUN);
   endfunction

endpackage

// File: rtl/instr_mem_loader_load_fsm.sv
// -----------------------------------------------------------------------------
// load_fsm
// Sequences program loads into the instruction store.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load_start      restart a program load (wins over load_valid)
//   load_valid      byte valid this cycle
//   load_last       final byte of the program
//   state           current FSM state (ST_EMPTY / ST_LOAD / ST_RUN)
//   load_ready      high only while in ST_LOAD
//   cpu_run         registered copy of (state == ST_RUN)
//   prog_len        bytes in the current program (ADDR_W+1 bits)
//   load_err        sticky overflow flag
//   mem_we          write strobe for the program store
//   mem_waddr       write address for the program store
// -----------------------------------------------------------------------------
module instr_mem_loader_load_fsm
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic              load_last,
   output logic [1:0]        state,
   output logic              load_ready,
   output logic              cpu_run,
   output logic [ADDR_W:0]   prog_len,
   output logic              load_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr
);

   // Pointer value of the final storable byte; reaching it ends the load.
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

   logic [1:0]      state_q,    state_d;
   logic [ADDR_W:0] wr_ptr_q,   wr_ptr_d;
   logic [ADDR_W:0] prog_len_q, prog_len_d;
   logic            load_err_q, load_err_d;
   logic            cpu_run_q,  cpu_run_d;
   // Set for exactly one cycle after a load that filled the store without
   // load_last; a byte offered in that cycle is the overflow byte.
   logic            ovf_pend_q, ovf_pend_d;
   logic            accept;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      prog_len_d = prog_len_q;
      load_err_d = load_err_q;
      ovf_pend_d = 1'b0;
      mem_we     = 1'b0;
      accept     = (state_q == ST_LOAD) && load_valid && !load_start;

      if (ovf_pend_q && load_valid) begin
         load_err_d = 1'b1;
      end

      if (load_start) begin
         // Restart from any state; earlier array contents stay but are
         // no longer counted.
         state_d    = ST_LOAD;
         wr_ptr_d   = '0;
         prog_len_d = '0;
         load_err_d = 1'b0;
      end else if (accept) begin
         mem_we     = 1'b1;
         wr_ptr_d   = wr_ptr_q + 1'b1;
         prog_len_d = wr_ptr_q + 1'b1;
         if (load_last) begin
            state_d = ST_RUN;
         end else if (wr_ptr_q == LAST_PTR) begin
            // Store is full: finish the load instead of wrapping.
            state_d    = ST_RUN;
            ovf_pend_d = 1'b1;
         end
      end

      cpu_run_d = state_is_run(state_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_EMPTY;
         wr_ptr_q   <= '0;
         prog_len_q <= '0;
         load_err_q <= 1'b0;
         ovf_pend_q <= 1'b0;
         cpu_run_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         prog_len_q <= prog_len_d;
         load_err_q <= load_err_d;
         ovf_pend_q <= ovf_pend_d;
         cpu_run_q  <= cpu_run_d;
      end
   end

   assign state      = state_q;
   assign load_ready = (state_q == ST_LOAD);
   assign cpu_run    = cpu_run_q;
   assign prog_len   = prog_len_q;
   assign load_err   = load_err_q;
   assign mem_waddr  = wr_ptr_q[ADDR_W-1:0];

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Loadable program store answering the core's instruction fetches.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   Read_Address    fetch address from the core's PC
//   instruction     fetched word (combinational, zero latency)
//   load_start      begin a new program load
//   load_valid      load_data valid this cycle
//   load_data       program byte
//   load_last       marks the final program byte
//   load_ready      store accepts a byte this cycle
//   cpu_run         core may execute while high
//   prog_len        bytes in the current program
//   load_err        sticky overflow flag
// DEPTH must not exceed 2**ADDR_W and must be at least 2.
// -----------------------------------------------------------------------------
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int         ADDR_W    = 8,
   parameter int         DEPTH     = 256,
   parameter logic [7:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Read_Address,
   output logic [7:0]        instruction,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [7:0]        load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              cpu_run,
   output logic [ADDR_W:0]   prog_len,
   output logic              load_err
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [1:0]        state;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [7:0]        mem [DEPTH];
   logic              fetch_hit;

   instr_mem_loader_load_fsm #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_load_fsm (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_last  (load_last),
      .state      (state),
      .load_ready (load_ready),
      .cpu_run    (cpu_run),
      .prog_len   (prog_len),
      .load_err   (load_err),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr)
   );

   // Program store; contents survive reset and reloads, validity is
   // tracked solely by state and prog_len.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr[IDX_W-1:0]] <= load_data;
      end
   end

   // Because prog_len never exceeds DEPTH, a hit also guarantees the
   // truncated index below addresses a written location.
   assign fetch_hit   = state_is_run(state) && ({1'b0, Read_Address} < prog_len);
   assign instruction = fetch_hit ? mem[Read_Address[IDX_W-1:0]] : NOP_INSTR;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
// Directed and randomized stimulus for instr_mem_loader, checked every cycle
// against a behavioural model of the loader.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] Read_Address = '0;
   logic [7:0]        instruction;
   logic              load_start = 1'b0;
   logic              load_valid = 1'b0;
   logic [7:0]        load_data = '0;
   logic              load_last = 1'b0;
   logic              load_ready;
   logic              cpu_run;
   logic [ADDR_W:0]   prog_len;
   logic              load_err;

   always #5 clk = ~clk;

   instr_mem_loader #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .NOP_INSTR (8'h00)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Read_Address (Read_Address),
      .instruction  (instruction),
      .load_start   (load_start),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_last    (load_last),
      .load_ready   (load_ready),
      .cpu_run      (cpu_run),
      .prog_len     (prog_len),
      .load_err     (load_err)
   );

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- behavioural model ----------------
   logic [7:0] mem_m [DEPTH];
   bit loading_m, running_m, err_m, pend_m;
   int wr_m, len_m;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] fetch_m(input int ra);
      return (running_m && ra < len_m) ? mem_m[ra] : 8'h00;
   endfunction

   task automatic model_reset();
      loading_m = 0; running_m = 0; err_m = 0; pend_m = 0; wr_m = 0; len_m = 0;
   endtask

   // One clock edge of the loader as seen from its ports.
   task automatic model_step();
      bit pend_next = 0;
      if (pend_m && load_valid) err_m = 1;
      if (load_start) begin
         loading_m = 1; running_m = 0; wr_m = 0; len_m = 0; err_m = 0;
      end else if (loading_m && load_valid) begin
         mem_m[wr_m] = load_data;
         wr_m++;
         len_m = wr_m;
         if (load_last || wr_m == DEPTH) begin
            loading_m = 0;
            running_m = 1;
            pend_next = !load_last;
            $display("load complete: %0d bytes%s", len_m, load_last ? "" : " (store full)");
         end
      end
      pend_m = pend_next;
   endtask

   task automatic check_outputs();
      check_val("load_ready",  load_ready,  loading_m);
      check_val("cpu_run",     cpu_run,     running_m);
      check_val("prog_len",    prog_len,    len_m);
      check_val("load_err",    load_err,    err_m);
      check_val("instruction", instruction, fetch_m(int'(Read_Address)));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic start_load();
      load_start = 1; load_valid = 0; load_last = 0;
      cycle();
      load_start = 0;
   endtask

   task automatic send_bytes(input logic [7:0] bytes [$], input int gap, input bit mark_last);
      foreach (bytes[i]) begin
         if (i > 0) repeat (gap) begin
            load_valid = 0;
            cycle();
         end
         load_valid = 1;
         load_data  = bytes[i];
         load_last  = mark_last && (i == bytes.size() - 1);
         cycle();
      end
      load_valid = 0;
      load_last  = 0;
   endtask

   task automatic probe(input logic [ADDR_W-1:0] ra, input logic [7:0] exp, input string tag);
      Read_Address = ra;
      #1;
      check_val(tag, instruction, exp);
   endtask

   logic [7:0] prog_q [$];
   logic [7:0] big_q [$];

   initial begin
      // ---------------- reset ----------------
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      for (int ra = 0; ra < 4; ra++) probe(ADDR_W'(ra), 8'h00, "reset_fetch");
      check_val("reset_len", prog_len, 0);
      reset = 1;

      // ---------------- basic 3-byte load ----------------
      Read_Address = 8'd1;
      prog_q = '{8'h41, 8'h92, 8'hC3};
      start_load();
      send_bytes(prog_q, 0, 1);
      check_val("basic_len", prog_len, 3);
      check_val("basic_run", cpu_run, 1);
      probe(8'd1, 8'h92, "basic_ra1");
      probe(8'd3, 8'h00, "basic_ra3");

      // ---------------- same load with 2-cycle gaps ----------------
      start_load();
      send_bytes(prog_q, 2, 1);
      check_val("gap_len", prog_len, 3);
      probe(8'd0, 8'h41, "gap_ra0");
      probe(8'd2, 8'hC3, "gap_ra2");

      // ---------------- reload from RUN ----------------
      Read_Address = 8'd0;
      start_load();
      check_val("reload_run", cpu_run, 0);
      check_val("reload_nop", instruction, 8'h00);
      prog_q = '{8'h55};
      send_bytes(prog_q, 0, 1);
      check_val("reload_len", prog_len, 1);
      probe(8'd1, 8'h00, "reload_ra1");
      probe(8'd0, 8'h55, "reload_ra0");

      // ---------------- load_start beats load_valid ----------------
      start_load();
      prog_q = '{8'h10, 8'h20};
      send_bytes(prog_q, 0, 0);
      load_start = 1; load_valid = 1; load_data = 8'hAA;
      cycle();
      load_start = 0; load_valid = 0;
      check_val("restart_len", prog_len, 0);
      prog_q = '{8'h01, 8'h02};
      send_bytes(prog_q, 1, 1);
      check_val("restart_len2", prog_len, 2);
      probe(8'd0, 8'h01, "restart_ra0");

      // ---------------- overflow: full store, then one extra byte ----------
      big_q.delete();
      for (int i = 0; i < DEPTH; i++) big_q.push_back(8'($urandom));
      start_load();
      send_bytes(big_q, 0, 0);
      check_val("full_len", prog_len, DEPTH);
      check_val("full_run", cpu_run, 1);
      load_valid = 1; load_data = 8'hEE;
      cycle();
      load_valid = 0;
      check_val("ovf_err", load_err, 1);
      check_val("ovf_len", prog_len, DEPTH);
      probe(8'd255, big_q[255], "ovf_ra255");
      probe(8'd0, big_q[0], "ovf_ra0");
      start_load();
      check_val("err_clear", load_err, 0);

      // ---------------- asynchronous reset mid-load ----------------
      prog_q = '{8'h31, 8'h32, 8'h33};
      send_bytes(prog_q, 0, 0);
      #3 reset = 0;
      #1;
      model_reset();
      check_outputs();
      check_val("arst_len", prog_len, 0);
      #2 reset = 1;
      load_valid = 1; load_data = 8'h77;
      repeat (3) cycle();
      load_valid = 0;
      check_val("arst_valid_len", prog_len, 0);

      // ---------------- randomized traffic ----------------
      for (int n = 0; n < 1500; n++) begin
         load_start   = ($urandom_range(0, 39) == 0);
         load_valid   = ($urandom_range(0, 2) != 0);
         load_last    = ($urandom_range(0, 11) == 0);
         load_data    = 8'($urandom);
         Read_Address = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         cycle();
      end
      load_start = 0; load_valid = 0; load_last = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard time bound so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction-side responder for the 8-bit microprocessor. It answers the core's Read_Address with an 8-bit instruction word.
- Holds a loadable program store: DEPTH x 8 register array.
- A byte-stream load interface with a valid/ready handshake fills the store. A small FSM gates execution and drives cpu_run, which the top level uses to hold the core's PC.
- Sits between the board input logic (switch/UART byte source) and the core's instruction port.

Parameters:
- ADDR_W, 8, address width; matches Read_Address width.
- DEPTH, 256, number of program bytes; must satisfy DEPTH <= 2**ADDR_W.
- NOP_INSTR, 8'h00, word returned for any fetch that is not a valid program byte.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Read_Address  in  ADDR_W  fetch address from the core's PC.
- instruction  out  8  fetched instruction word to the core.
- load_start  in  1  single-cycle request to begin a new program load.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  8  program byte.
- load_last  in  1  qualifies the final byte of a program; sampled together with load_valid.
- load_ready  out  1  block accepts a byte this cycle.
- cpu_run  out  1  high only in RUN; the core executes while this is high.
- prog_len  out  ADDR_W+1  number of bytes in the current program.
- load_err  out  1  sticky overflow flag; cleared by load_start or reset.

Behaviour:
- Reset (reset=0, asynchronous): state=EMPTY, wr_ptr=0, prog_len=0, load_err=0, cpu_run=0, load_ready=0. Array contents are not reset.
- FSM states and transitions:
  - EMPTY: load_start -> LOAD.
  - LOAD: the byte carrying load_last, or a write to address DEPTH-1, -> RUN.
  - RUN: load_start -> LOAD.
- Entering LOAD: on the load_start cycle, wr_ptr<=0, prog_len<=0, load_err<=0, cpu_run<=0 (next cycle).
- load_ready=1 only in LOAD (registered state, not combinational on load_valid).
- Byte acceptance:
  - A byte is accepted on a cycle with load_valid & load_ready.
  - On acceptance: mem[wr_ptr]<=load_data, wr_ptr<=wr_ptr+1, prog_len<=wr_ptr+1.
- Last byte: if the accepted byte has load_last=1, go to RUN next cycle. prog_len includes that byte.
- Overflow:
  - A byte accepted at wr_ptr=DEPTH-1 without load_last still finishes the load: go to RUN and set prog_len=DEPTH.
  - load_err<=1 only if load_valid is asserted in the cycle after that final accept. In that cycle the block is already in RUN and the byte is dropped.
  - No pointer wrap ever occurs.
- load_valid outside LOAD: ignored and never written. In EMPTY and RUN it has no effect.
- load_start during LOAD: restarts the load (pointer to 0, prog_len to 0). Bytes already written are kept in the array but not counted.
- load_start together with load_valid in the same LOAD cycle: load_start wins and the byte is dropped.
- Fetch (combinational, zero latency, so the core's single-cycle fetch is unaffected):
  - instruction = mem[Read_Address] when state=RUN and Read_Address < prog_len.
  - Otherwise instruction = NOP_INSTR.
  - This covers EMPTY, LOAD, and fetches past the program end or beyond DEPTH.
- cpu_run: registered, equals (state==RUN). It drops on the cycle after load_start, so the core stalls during reload.
- Reset mid-load: returns to EMPTY, prog_len=0, and the partially loaded program is discarded logically.
- Width rule: prog_len is ADDR_W+1 bits so that DEPTH=256 is representable. The comparison Read_Address < prog_len is zero-extended.

Decomposition:
- Shared package: FSM state encoding (EMPTY=2'd0, LOAD=2'd1, RUN=2'd2) and the default NOP_INSTR constant, shared with ControlUnit decode.
- One natural sub-module: load_fsm. It holds state, wr_ptr, prog_len and load_err, and outputs the write enable and address.
- The top level holds the array and the fetch mux.

Test Plan:
- Reset, then drive Read_Address=0..3 -> instruction=8'h00, cpu_run=0, load_ready=0, prog_len=0.
- load_start, then stream 8'h41, 8'h92, 8'hC3 (last on 8'hC3) with load_valid held high -> load_ready=1 for 3 cycles, then cpu_run=1 and prog_len=3.
  - Read_Address=1 -> 8'h92.
  - Read_Address=3 -> 8'h00.
- During streaming, toggle load_valid low for 2 cycles between bytes -> no writes in those cycles, same final contents and prog_len=3.
- DEPTH=4 build: stream 5 bytes with no load_last -> RUN after the 4th byte, prog_len=4, load_err=1, mem[0..3] correct, 5th byte absent.
- From RUN with prog_len=3, pulse load_start -> cpu_run=0 next cycle and instruction=NOP_INSTR.
  - Then load 1 byte 8'h55 with last -> prog_len=1.
  - Read_Address=1 -> 8'h00 even though the old data is still in the array.
- Assert reset low mid-LOAD, asynchronously between clock edges -> state EMPTY immediately, load_ready=0, prog_len=0.
  - After reset is released, load_valid alone writes nothing.
